// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
//
// Purpose:
//   Parametrised UART receive deframer. The serial line is oversampled on an
//   external sample_tick (OVERSAMPLE ticks per bit period). The block checks
//   the start bit at its centre, shifts WORD_LENGTH data bits in LSB-first,
//   optionally checks a parity bit and then samples the stop bit. Each
//   finished word is held in an output buffer under a valid/ack handshake.
//
// Optional feature (compile-time macro):
//   UART_RX_PARITY_EN - when defined, a parity bit is expected between the
//                       last data bit and the stop bit, and parity_error
//                       reports a mismatch. When undefined, the frame is
//                       start + data + stop and parity_error is tied to 0.
//
// Parameters:
//   WORD_LENGTH  data bits per frame (5..9)
//   OVERSAMPLE   sample_tick pulses per bit period (even, >= 4)
//   PARITY_ODD   0 = even parity, 1 = odd parity (parity build only)
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   sample_tick    in   1-clk enable at OVERSAMPLE x baud
//   SerialDataIn   in   serial line, idle high, already synchronised
//   rx_ack         in   host consumes the buffered word
//   DataRX         out  received word, stable while rx_valid = 1
//   rx_valid       out  buffered word available
//   parity_error   out  parity mismatch for the buffered word
//   framing_error  out  stop bit sampled 0 for the buffered word
//   overrun        out  sticky: a word was overwritten before rx_ack
//   rx_busy        out  receiver is in any state other than IDLE
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int WORD_LENGTH = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_ODD  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic                   SerialDataIn,
    input  logic                   rx_ack,
    output logic [WORD_LENGTH-1:0] DataRX,
    output logic                   rx_valid,
    output logic                   parity_error,
    output logic                   framing_error,
    output logic                   overrun,
    output logic                   rx_busy
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(WORD_LENGTH);

    // Tick count at which the start bit centre is reached (half a bit in).
    localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
    // Tick count at which the centre of every following bit is reached.
    localparam logic [TCW-1:0] BIT_LAST  = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] WORD_LAST = BCW'(WORD_LENGTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    // Expected parity bit for a received word.
    function automatic logic parity_expected(input logic [WORD_LENGTH-1:0] data);
        parity_expected = (^data) ^ PARITY_ODD[0];
    endfunction

    state_t                 state_r,    state_s;
    logic [TCW-1:0]         tick_cnt_r, tick_cnt_s;
    logic [BCW-1:0]         bit_cnt_r,  bit_cnt_s;
    logic [WORD_LENGTH-1:0] shift_r,    shift_s;
    // Set once the line has been sampled high; a start is accepted only then,
    // so a line stuck low after a framing error cannot retrigger a frame.
    logic                   armed_r,    armed_s;
    logic                   commit_s;
    logic                   frame_err_s;
    logic                   ack_s;

    logic [WORD_LENGTH-1:0] data_rx_r;
    logic                   rx_valid_r;
    logic                   framing_error_r;
    logic                   overrun_r;
    logic                   rx_busy_r;

`ifdef UART_RX_PARITY_EN
    logic                   par_err_r, par_err_s;
    logic                   parity_error_r;
`endif

    // Receiver state register and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            armed_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_r  <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            armed_r    <= armed_s;
`ifdef UART_RX_PARITY_EN
            par_err_r  <= par_err_s;
`endif
        end
    end

    // Next-state, counter and shift logic; everything advances only on a tick.
    always_comb begin
        state_s     = state_r;
        tick_cnt_s  = tick_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        armed_s     = armed_r;
        commit_s    = 1'b0;
        frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_s   = par_err_r;
`endif
        if (sample_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (SerialDataIn) begin
                        armed_s = 1'b1;
                    end else if (armed_r) begin
                        state_s    = ST_START;
                        tick_cnt_s = '0;
                        armed_s    = 1'b0;
                    end else begin
                        armed_s = armed_r;
                    end
                end
                ST_START: begin
                    if (tick_cnt_r == HALF_LAST) begin
                        tick_cnt_s = '0;
                        if (SerialDataIn) begin
                            // Line back high at start centre: glitch, drop it.
                            state_s = ST_IDLE;
                            armed_s = 1'b1;
                        end else begin
                            state_s   = ST_DATA;
                            bit_cnt_s = '0;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TCW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_s = '0;
                        // LSB arrives first, so each bit enters at the MSB.
                        shift_s    = {SerialDataIn, shift_r[WORD_LENGTH-1:1]};
                        if (bit_cnt_r == WORD_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_s = ST_PARITY;
`else
                            state_s = ST_STOP;
`endif
                        end else begin
                            bit_cnt_s = bit_cnt_r + BCW'(1);
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TCW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_s = '0;
                        par_err_s  = (SerialDataIn != parity_expected(shift_r));
                        state_s    = ST_STOP;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TCW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_cnt_r == BIT_LAST) begin
                        tick_cnt_s  = '0;
                        commit_s    = 1'b1;
                        frame_err_s = ~SerialDataIn;
                        armed_s     = SerialDataIn;
                        state_s     = ST_IDLE;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TCW'(1);
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    tick_cnt_s = '0;
                    bit_cnt_s  = '0;
                    armed_s    = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // A host ack only counts while a word is actually buffered.
    assign ack_s = rx_ack & rx_valid_r;

    // Output buffer, handshake flags and busy indicator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_rx_r       <= '0;
            rx_valid_r      <= 1'b0;
            framing_error_r <= 1'b0;
            overrun_r       <= 1'b0;
            rx_busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_r  <= 1'b0;
`endif
        end else begin
            rx_busy_r <= (state_s != ST_IDLE);
            if (commit_s) begin
                data_rx_r       <= shift_r;
                framing_error_r <= frame_err_s;
                rx_valid_r      <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_error_r  <= par_err_r;
`endif
                // Overwriting an unacknowledged word loses it; an ack on the
                // same edge means the old word was taken, so nothing is lost.
                if (rx_valid_r && !rx_ack) begin
                    overrun_r <= 1'b1;
                end else if (ack_s) begin
                    overrun_r <= 1'b0;
                end else begin
                    overrun_r <= overrun_r;
                end
            end else if (ack_s) begin
                rx_valid_r <= 1'b0;
                overrun_r  <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign DataRX        = data_rx_r;
    assign rx_valid      = rx_valid_r;
    assign framing_error = framing_error_r;
    assign overrun       = overrun_r;
    assign rx_busy       = rx_busy_r;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_error_r;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
//
// Directed bench for uart_rx_deframer (WORD_LENGTH=8, OVERSAMPLE=16, one
// sample_tick every clk). Frames are driven bit by bit on the falling edge;
// each frame pushes its expected word into a scoreboard queue, and the queue
// is popped when the DUT presents a buffered word. With UART_RX_PARITY_EN
// defined the frames carry an even parity bit and the parity cases run.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;

    localparam int WL = 8;
    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Start centre after OS/2 ticks, then WL (+parity) + stop bit centres,
    // plus one clk for the commit edge to become visible.
    localparam int COMMIT_LAT = OS / 2 + (FRAME_BITS - 1) * OS + 1;

    typedef struct packed {
        logic [WL-1:0] data;
        logic          pe;
        logic          fe;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          sample_tick;
    logic          SerialDataIn;
    logic          rx_ack;
    logic [WL-1:0] DataRX;
    logic          rx_valid;
    logic          parity_error;
    logic          framing_error;
    logic          overrun;
    logic          rx_busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic exp_valid   = 1'b0;
    logic exp_overrun = 1'b0;

    uart_rx_deframer #(
        .WORD_LENGTH(WL),
        .OVERSAMPLE (OS),
        .PARITY_ODD (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .SerialDataIn (SerialDataIn),
        .rx_ack       (rx_ack),
        .DataRX       (DataRX),
        .rx_valid     (rx_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .overrun      (overrun),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        SerialDataIn = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard push: a frame sent while the previous word is unacked
    // replaces it and makes overrun expected.
    task automatic push_expected(input logic [WL-1:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.fe   = fe;
        if (exp_valid) begin
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            exp_overrun = 1'b1;
        end
        sb_q.push_back(e);
        exp_valid = 1'b1;
    endtask

    // Drives one full frame; returns the cycle at which rx_valid rose (or -1).
    task automatic send_frame(input logic [WL-1:0] d, input logic stop_b,
                              input logic par_flip, output int rise_at);
        logic [10:0] bits;
        logic        prev_v;
        bits    = 11'h7FF;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^d) ^ par_flip;
        bits[10] = stop_b;
        push_expected(d, par_flip, ~stop_b);
`else
        bits[9]  = stop_b;
        push_expected(d, 1'b0, ~stop_b);
`endif
        rise_at = -1;
        prev_v  = rx_valid;
        for (int c = 0; c < FRAME_BITS * OS; c++) begin
            SerialDataIn = bits[c / OS];
            @(negedge clk);
            if (rise_at < 0 && !prev_v && rx_valid) rise_at = c + 1;
            prev_v = rx_valid;
        end
        SerialDataIn = 1'b1;
    endtask

    // Waits (bounded) for a buffered word and compares it with the scoreboard.
    task automatic expect_word(input string tag);
        exp_t e;
        for (int i = 0; i < 400 && !rx_valid; i++) @(negedge clk);
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_data"},    {24'd0, DataRX},      {24'd0, e.data});
            check({tag, "_parity"},  {31'd0, parity_error}, {31'd0, e.pe});
            check({tag, "_framing"}, {31'd0, framing_error}, {31'd0, e.fe});
        end
        check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, exp_overrun});
    endtask

    task automatic ack_word(input string tag);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
        check({tag, "_ack_valid"},   {31'd0, rx_valid}, 32'd0);
        check({tag, "_ack_overrun"}, {31'd0, overrun},  32'd0);
    endtask

    initial begin
        int   rise;
        logic saw_busy;
        reset        = 1'b1;
        sample_tick  = 1'b1;
        SerialDataIn = 1'b1;
        rx_ack       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data",    {24'd0, DataRX},       32'd0);
        check("rst_valid",   {31'd0, rx_valid},     32'd0);
        check("rst_parity",  {31'd0, parity_error}, 32'd0);
        check("rst_framing", {31'd0, framing_error}, 32'd0);
        check("rst_overrun", {31'd0, overrun},      32'd0);
        check("rst_busy",    {31'd0, rx_busy},      32'd0);
        reset = 1'b0;
        idle(5);

        // 1) clean 0xA5 frame, commit latency
        send_frame(8'hA5, 1'b1, 1'b0, rise);
        check("t1_latency", rise, COMMIT_LAT);
        check("t1_busy_idle", {31'd0, rx_busy}, 32'd0);
        expect_word("t1");
        ack_word("t1");
        idle(4);

        // 2) 4-tick start glitch: busy pulses, nothing buffered
        saw_busy = 1'b0;
        SerialDataIn = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_busy = saw_busy | rx_busy;
        end
        SerialDataIn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            saw_busy = saw_busy | rx_busy;
        end
        check("t2_busy_pulse", {31'd0, saw_busy}, 32'd1);
        check("t2_busy_end",   {31'd0, rx_busy},  32'd0);
        check("t2_no_valid",   {31'd0, rx_valid}, 32'd0);

        // 3) framing error on 0x3C, cleared by the next good frame
        send_frame(8'h3C, 1'b0, 1'b0, rise);
        expect_word("t3_bad");
        ack_word("t3_bad");
        idle(6);
        send_frame(8'h81, 1'b1, 1'b0, rise);
        expect_word("t3_good");
        ack_word("t3_good");
        idle(4);

`ifdef UART_RX_PARITY_EN
        // 4) even parity: correct bit, then inverted bit
        send_frame(8'h07, 1'b1, 1'b0, rise);
        expect_word("t4_par_ok");
        ack_word("t4_par_ok");
        idle(4);
        send_frame(8'h07, 1'b1, 1'b1, rise);
        expect_word("t4_par_bad");
        ack_word("t4_par_bad");
        idle(4);
`endif

        // 5) two frames without ack -> overrun, ack clears
        send_frame(8'h11, 1'b1, 1'b0, rise);
        idle(4);
        send_frame(8'h22, 1'b1, 1'b0, rise);
        expect_word("t5");
        ack_word("t5");
        idle(4);

        // 6) reset at DATA bit 4 of 0xFF with an unacked word buffered
        send_frame(8'h33, 1'b1, 1'b0, rise);
        expect_word("t6_pre");
        idle(4);
        SerialDataIn = 1'b0;
        repeat (OS) @(negedge clk);
        SerialDataIn = 1'b1;
        repeat (4 * OS + OS / 2) @(negedge clk);
        check("t6_busy_mid", {31'd0, rx_busy}, 32'd1);
        reset = 1'b1;
        sb_q.delete();
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
        @(negedge clk);
        check("t6_rst_data",    {24'd0, DataRX},        32'd0);
        check("t6_rst_valid",   {31'd0, rx_valid},      32'd0);
        check("t6_rst_framing", {31'd0, framing_error}, 32'd0);
        check("t6_rst_overrun", {31'd0, overrun},       32'd0);
        check("t6_rst_busy",    {31'd0, rx_busy},       32'd0);
        reset = 1'b0;
        idle(20);
        send_frame(8'h5A, 1'b1, 1'b0, rise);
        check("t6_latency", rise, COMMIT_LAT);
        expect_word("t6_post");
        ack_word("t6_post");
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
